// File: rtl/strip_pkg.sv
// Shared constants, height table and FSM encoding for the strip ID -> height/base lookup.
package strip_pkg;

  localparam int unsigned NUM_STRIPS         = 13;
  localparam int unsigned ID_W               = 4;
  localparam int unsigned HEIGHT_W           = 5;
  localparam int unsigned BASE_W             = 8;
  localparam int unsigned TOTAL_STACK_HEIGHT = 130;

  // Indexed by strip ID; entry 0 and IDs beyond NUM_STRIPS read as zero height.
  localparam logic [HEIGHT_W-1:0] STRIP_HEIGHT [0:2**ID_W-1] = '{
    5'd0,  5'd16, 5'd15, 5'd9,  5'd7,  5'd10, 5'd6,  5'd11,
    5'd5,  5'd12, 5'd4,  5'd8,  5'd14, 5'd13, 5'd0,  5'd0
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_RESP  = 2'd2
  } strip_state_e;

endpackage

// File: rtl/strip_height_rom.sv
// Combinational strip height lookup; out-of-range IDs return zero.
module strip_height_rom
  import strip_pkg::*;
(
  input  logic [ID_W-1:0]     id_i,
  output logic [HEIGHT_W-1:0] height_o
);

  always_comb begin
    height_o = '0;
    if (id_i <= ID_W'(NUM_STRIPS)) begin
      height_o = STRIP_HEIGHT[id_i];
    end
  end

endmodule

// File: rtl/strip_id_to_height.sv
// Maps a strip ID to its height and y-base, accumulating lower strip heights one per cycle.
module strip_id_to_height
  import strip_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [ID_W-1:0]     req_id_i,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [HEIGHT_W-1:0] resp_height_o,
  output logic [BASE_W-1:0]   resp_base_o,
  output logic                resp_err_o
);

  strip_state_e        state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     k_q, k_d;
  logic [BASE_W-1:0]   acc_q, acc_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [HEIGHT_W-1:0] resp_height_q, resp_height_d;
  logic [BASE_W-1:0]   resp_base_q, resp_base_d;
  logic                resp_err_q, resp_err_d;
  logic [HEIGHT_W-1:0] k_height;
  logic [HEIGHT_W-1:0] id_height;
  logic                id_in_range;

  strip_height_rom u_rom_k (
    .id_i     (k_q),
    .height_o (k_height)
  );

  strip_height_rom u_rom_id (
    .id_i     (id_q),
    .height_o (id_height)
  );

  assign id_in_range = (req_id_i != '0) && (req_id_i <= ID_W'(NUM_STRIPS));

  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    k_d           = k_q;
    acc_d         = acc_q;
    resp_height_d = resp_height_q;
    resp_base_d   = resp_base_q;
    resp_err_d    = resp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          id_d  = req_id_i;
          acc_d = '0;
          k_d   = ID_W'(1);
          if (id_in_range) begin
            state_d = ST_ACCUM;
          end else begin
            state_d       = ST_RESP;
            resp_err_d    = 1'b1;
            resp_height_d = '0;
            resp_base_d   = '0;
          end
        end
      end
      ST_ACCUM: begin
        // acc holds the sum of heights of strips 1..k-1 on entry to each cycle
        if (k_q == id_q) begin
          state_d       = ST_RESP;
          resp_err_d    = 1'b0;
          resp_height_d = id_height;
          resp_base_d   = acc_q;
        end else begin
          acc_d = acc_q + BASE_W'(k_height);
          k_d   = k_q + ID_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      id_q          <= '0;
      k_q           <= '0;
      acc_q         <= '0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_height_q <= '0;
      resp_base_q   <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      k_q           <= k_d;
      acc_q         <= acc_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_height_q <= resp_height_d;
      resp_base_q   <= resp_base_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign req_ready_o   = req_ready_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_height_o = resp_height_q;
  assign resp_base_o   = resp_base_q;
  assign resp_err_o    = resp_err_q;

endmodule

// File: tb/tb_strip_id_to_height.sv
// Randomized self-checking bench for strip_id_to_height against a table/summation model.
module tb_strip_id_to_height;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       req_valid_i;
  logic       req_ready_o;
  logic [3:0] req_id_i;
  logic       resp_valid_o;
  logic       resp_ready_i;
  logic [4:0] resp_height_o;
  logic [7:0] resp_base_o;
  logic       resp_err_o;

  int n_checks = 0;
  int n_pass   = 0;

  int ref_h [0:13] = '{0, 16, 15, 9, 7, 10, 6, 11, 5, 12, 4, 8, 14, 13};

  strip_id_to_height dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_id_i      (req_id_i),
    .resp_valid_o  (resp_valid_o),
    .resp_ready_i  (resp_ready_i),
    .resp_height_o (resp_height_o),
    .resp_base_o   (resp_base_o),
    .resp_err_o    (resp_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int model_height(input int id);
    return (id >= 1 && id <= 13) ? ref_h[id] : 0;
  endfunction

  function automatic int model_base(input int id);
    int s = 0;
    if (id < 1 || id > 13) return 0;
    for (int i = 1; i < id; i++) s += ref_h[i];
    return s;
  endfunction

  // Issue one request, optionally stall the response for bp cycles, then check everything.
  task automatic do_req(input int id, input int bp, input string tag);
    int cnt;
    int exp_h, exp_b, exp_e, exp_lat;
    logic seen;
    exp_e   = (id < 1 || id > 13) ? 1 : 0;
    exp_h   = model_height(id);
    exp_b   = model_base(id);
    exp_lat = exp_e ? 1 : id + 1;

    @(negedge clk_i);
    check_eq({tag, " ready_before"}, int'(req_ready_o), 1);
    req_valid_i  = 1'b1;
    req_id_i     = 4'(id);
    resp_ready_i = (bp == 0);
    @(posedge clk_i);
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 40) begin
      @(negedge clk_i);
      cnt++;
      if (resp_valid_o) begin
        seen = 1'b1;
      end else begin
        req_valid_i = 1'($urandom_range(0, 1));
        req_id_i    = 4'($urandom_range(0, 15));
      end
    end
    check_eq({tag, " resp_seen"}, int'(seen), 1);
    if (!seen) return;
    check_eq({tag, " latency"}, cnt, exp_lat);
    check_eq({tag, " height"}, int'(resp_height_o), exp_h);
    check_eq({tag, " base"}, int'(resp_base_o), exp_b);
    check_eq({tag, " err"}, int'(resp_err_o), exp_e);
    check_eq({tag, " ready_busy"}, int'(req_ready_o), 0);

    req_valid_i = (bp > 0);
    req_id_i    = 4'($urandom_range(0, 15));
    for (int i = 0; i < bp; i++) begin
      @(negedge clk_i);
      check_eq({tag, " bp_valid"}, int'(resp_valid_o), 1);
      check_eq({tag, " bp_ready"}, int'(req_ready_o), 0);
      check_eq({tag, " bp_height"}, int'(resp_height_o), exp_h);
      check_eq({tag, " bp_base"}, int'(resp_base_o), exp_b);
      check_eq({tag, " bp_err"}, int'(resp_err_o), exp_e);
    end
    req_valid_i  = 1'b0;
    resp_ready_i = 1'b1;
    @(negedge clk_i);
    check_eq({tag, " post_valid"}, int'(resp_valid_o), 0);
    check_eq({tag, " post_ready"}, int'(req_ready_o), 1);
    check_eq({tag, " held_height"}, int'(resp_height_o), exp_h);
    check_eq({tag, " held_base"}, int'(resp_base_o), exp_b);
    check_eq({tag, " held_err"}, int'(resp_err_o), exp_e);
  endtask

  int fwd_h  [0:7] = '{9, 10, 11, 12, 4, 5, 6, 7};
  int fwd_id [0:7] = '{3, 5, 7, 9, 10, 8, 6, 4};

  initial begin
    rst_ni       = 1'b0;
    req_valid_i  = 1'b0;
    req_id_i     = '0;
    resp_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst ready", int'(req_ready_o), 1);
    check_eq("rst valid", int'(resp_valid_o), 0);
    check_eq("rst height", int'(resp_height_o), 0);
    check_eq("rst base", int'(resp_base_o), 0);
    check_eq("rst err", int'(resp_err_o), 0);
    rst_ni = 1'b1;

    do_req(1, 0, "id1");
    do_req(4, 0, "id4");
    do_req(10, 0, "id10");
    do_req(13, 0, "id13");
    do_req(0, 0, "id0");
    do_req(14, 0, "id14");
    do_req(15, 2, "id15");
    do_req(6, 4, "id6_bp");

    // Reset in the middle of accumulation drops the transaction
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_id_i    = 4'd12;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check_eq("midrst valid", int'(resp_valid_o), 0);
    check_eq("midrst ready", int'(req_ready_o), 1);
    check_eq("midrst height", int'(resp_height_o), 0);
    check_eq("midrst base", int'(resp_base_o), 0);
    check_eq("midrst err", int'(resp_err_o), 0);
    rst_ni = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      check_eq("midrst no_resp", int'(resp_valid_o), 0);
    end
    do_req(2, 0, "id2_after_rst");

    for (int i = 0; i < 8; i++) begin
      do_req(fwd_id[i], 0, "roundtrip");
      check_eq("roundtrip height", int'(resp_height_o), fwd_h[i]);
    end

    for (int i = 0; i < 30; i++) begin
      do_req(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
